// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter_if
// Function : Issue, writeback, long-unit and register-file bundle for the
//            register-file write-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NR_REG     = 32
);
   logic                  issue_valid;
   logic [4:0]            issue_rs1;
   logic [4:0]            issue_rs2;
   logic [4:0]            issue_rd;
   logic                  issue_long;
   logic                  issue_stall;
   logic                  pipe_wen;
   logic [4:0]            pipe_rd;
   logic [DATA_WIDTH-1:0] pipe_data;
   logic                  lu_valid;
   logic [4:0]            lu_rd;
   logic [DATA_WIDTH-1:0] lu_data;
   logic                  lu_ready;
   logic                  rf_wen;
   logic [4:0]            rf_rd;
   logic [DATA_WIDTH-1:0] rf_wrdata;
   logic [NR_REG-1:0]     busy;

   modport slave (
      input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_long,
      input  pipe_wen, pipe_rd, pipe_data,
      input  lu_valid, lu_rd, lu_data,
      output issue_stall, lu_ready, rf_wen, rf_rd, rf_wrdata, busy
   );

   modport master (
      output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_long,
      output pipe_wen, pipe_rd, pipe_data,
      output lu_valid, lu_rd, lu_data,
      input  issue_stall, lu_ready, rf_wen, rf_rd, rf_wrdata, busy
   );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Function : Shares the register-file write port between pipeline writeback
//            and a buffered long-latency unit; keeps the busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int NR_REG     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input wire logic            clk,
   input wire logic            rst_n,
   regfile_wb_arbiter_if.slave bus
);
   localparam int C_PTR_W = $clog2(FIFO_DEPTH);
   localparam int C_CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int C_N_SRC = 3;
   localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(FIFO_DEPTH);

   logic [C_CNT_W-1:0]    count_q, count_d;
   logic [C_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [C_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [4:0]            fifo_rd_q   [FIFO_DEPTH];
   logic [4:0]            fifo_rd_d   [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
   logic [NR_REG-1:0]     busy_q, busy_d;

   logic                  pipe_act;
   logic                  fifo_empty;
   logic                  lu_ready;
   logic                  enq;
   logic                  drain;
   logic [4:0]            head_rd;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  issue_stall;
   logic                  issued;
   logic [4:0]            src [C_N_SRC];
   logic [C_N_SRC-1:0]    hz;
   logic                  rf_wen;
   logic [4:0]            rf_rd;
   logic [DATA_WIDTH-1:0] rf_wrdata;

   always_comb begin
      pipe_act   = bus.pipe_wen && (bus.pipe_rd != 5'd0);
      fifo_empty = (count_q == '0);
      // No lookahead: a full buffer refuses even when it drains this cycle.
      lu_ready   = rst_n && (count_q != C_FULL);
      enq        = bus.lu_valid && lu_ready && (bus.lu_rd != 5'd0);
      drain      = rst_n && !pipe_act && !fifo_empty;
      head_rd    = fifo_rd_q[rd_ptr_q];
      head_data  = fifo_data_q[rd_ptr_q];
   end

   always_comb begin
      rf_wen    = 1'b0;
      rf_rd     = 5'd0;
      rf_wrdata = '0;
      if (rst_n) begin
         if (pipe_act) begin
            rf_wen    = 1'b1;
            rf_rd     = bus.pipe_rd;
            rf_wrdata = bus.pipe_data;
         end else if (!fifo_empty) begin
            rf_wen    = 1'b1;
            rf_rd     = head_rd;
            rf_wrdata = head_data;
         end
      end
   end

   assign src[0] = bus.issue_rs1;
   assign src[1] = bus.issue_rs2;
   assign src[2] = bus.issue_rd;

   // A register being drained this cycle is forwarded by the register file.
   for (genvar gi = 0; gi < C_N_SRC; gi++) begin : g_hz
      assign hz[gi] = (src[gi] != 5'd0) && busy_q[src[gi]] &&
                      !(drain && (head_rd == src[gi]));
   end

   always_comb begin
      issue_stall = rst_n && bus.issue_valid && (|hz);
      issued      = bus.issue_valid && !issue_stall;
   end

   always_comb begin
      busy_d = busy_q;
      if (drain) begin
         busy_d[head_rd] = 1'b0;
      end
      if (issued && bus.issue_long && (bus.issue_rd != 5'd0)) begin
         busy_d[bus.issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      fifo_rd_d   = fifo_rd_q;
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (enq) begin
         fifo_rd_d[wr_ptr_q]   = bus.lu_rd;
         fifo_data_d[wr_ptr_q] = bus.lu_data;
         wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      if (drain) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({enq, drain})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         busy_q   <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         busy_q   <= busy_d;
      end
   end

   // Entry storage is only meaningful below count_q, so it needs no reset.
   always_ff @(posedge clk) begin
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
   end

   assign bus.issue_stall = issue_stall;
   assign bus.lu_ready    = lu_ready;
   assign bus.rf_wen      = rf_wen;
   assign bus.rf_rd       = rf_rd;
   assign bus.rf_wrdata   = rf_wrdata;
   assign bus.busy        = busy_q;

endmodule
`default_nettype wire
